// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd F(4x4,3x3) input-tile path.
package winograd_pkg;

    localparam int TILE_SIZE       = 6;
    localparam int TILE_STRIDE     = 4;
    localparam int TILE_PAD        = 1;
    localparam int TILE_ELEMS      = TILE_SIZE * TILE_SIZE;
    localparam int TILE_DATA_WIDTH = 16;

    // One 6x6 input tile, indexed [row][col]; shared with tile_transform_unit.
    typedef logic [0:TILE_SIZE-1][0:TILE_SIZE-1][TILE_DATA_WIDTH-1:0] tile_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        PRESENT,
        DONE
    } loader_state_e;

endpackage

// File: rtl/winograd_tile_loader_addr_gen.sv
// tile_addr_gen: walks the 36 element slots of the current tile, flags padded
// slots and produces RAM addresses by accumulation (no multiplier).
module tile_addr_gen
    import winograd_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DIM_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_i,      // latch frame parameters, rewind to tile (0,0)
    input  logic                  run_i,       // step one element slot
    input  logic                  adv_i,       // move to the next tile in row-major order
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [DIM_WIDTH-1:0]  img_h_i,
    input  logic [DIM_WIDTH-1:0]  img_w_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [5:0]            slot_idx_o,
    output logic                  last_slot_o,
    output logic [DIM_WIDTH-1:0]  tile_row_o,
    output logic [DIM_WIDTH-1:0]  tile_col_o,
    output logic                  last_tile_o
);

    // Pixel coordinates are carried with the pad added, so they are never negative.
    localparam int PW = DIM_WIDTH + 2;
    localparam int HW = DIM_WIDTH + 1;

    logic [DIM_WIDTH-1:0]  h_q, h_d, w_q, w_d;
    logic [DIM_WIDTH-1:0]  th_q, th_d, tw_q, tw_d;
    logic [DIM_WIDTH-1:0]  tr_q, tr_d, tc_q, tc_d;
    logic [2:0]            i_q, i_d, j_q, j_d;
    logic [5:0]            slot_q, slot_d;
    // Address of pixel (4*tr-1, -1): start of the current tile row band.
    logic [ADDR_WIDTH-1:0] trow_base_q, trow_base_d;
    // Address of the tile origin pixel (4*tr-1, 4*tc-1).
    logic [ADDR_WIDTH-1:0] tile_base_q, tile_base_d;
    // Address of pixel (4*tr-1+i, 4*tc-1): start of the current element row.
    logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;

    logic [PW-1:0]         prow, pcol;
    logic                  row_ok, col_ok, last_col;
    logic [HW-1:0]         th_calc, tw_calc;
    logic [ADDR_WIDTH-1:0] band_step, origin0;

    // Bounds check, address and tile-position flags for the current slot.
    always_comb begin
        prow        = {tr_q, 2'b00} + PW'(i_q);
        pcol        = {tc_q, 2'b00} + PW'(j_q);
        row_ok      = (prow >= PW'(TILE_PAD)) && (prow < PW'(h_q) + PW'(TILE_PAD));
        col_ok      = (pcol >= PW'(TILE_PAD)) && (pcol < PW'(w_q) + PW'(TILE_PAD));
        rd_en_o     = run_i && row_ok && col_ok;
        addr_o      = row_addr_q + ADDR_WIDTH'(j_q);
        slot_idx_o  = slot_q;
        last_slot_o = (slot_q == 6'(TILE_ELEMS - 1));
        last_col    = (tc_q == tw_q - DIM_WIDTH'(1));
        last_tile_o = last_col && (tr_q == th_q - DIM_WIDTH'(1));
        tile_row_o  = tr_q;
        tile_col_o  = tc_q;
        th_calc     = ({1'b0, img_h_i} + HW'(TILE_STRIDE - 1)) >> 2;
        tw_calc     = ({1'b0, img_w_i} + HW'(TILE_STRIDE - 1)) >> 2;
        band_step   = ADDR_WIDTH'({w_q, 2'b00});
        origin0     = base_addr_i - ADDR_WIDTH'(img_w_i) - ADDR_WIDTH'(TILE_PAD);
    end

    // Next-state for counters and address accumulators.
    always_comb begin
        h_d         = h_q;
        w_d         = w_q;
        th_d        = th_q;
        tw_d        = tw_q;
        tr_d        = tr_q;
        tc_d        = tc_q;
        i_d         = i_q;
        j_d         = j_q;
        slot_d      = slot_q;
        trow_base_d = trow_base_q;
        tile_base_d = tile_base_q;
        row_addr_d  = row_addr_q;
        if (init_i) begin
            h_d         = img_h_i;
            w_d         = img_w_i;
            th_d        = th_calc[DIM_WIDTH-1:0];
            tw_d        = tw_calc[DIM_WIDTH-1:0];
            tr_d        = '0;
            tc_d        = '0;
            i_d         = '0;
            j_d         = '0;
            slot_d      = '0;
            trow_base_d = origin0;
            tile_base_d = origin0;
            row_addr_d  = origin0;
        end else if (run_i) begin
            if (last_slot_o) begin
                // Rewind so the same tile could be re-walked; adv_i moves it on.
                i_d        = '0;
                j_d        = '0;
                slot_d     = '0;
                row_addr_d = tile_base_q;
            end else begin
                slot_d = slot_q + 6'd1;
                if (j_q == 3'(TILE_SIZE - 1)) begin
                    j_d        = '0;
                    i_d        = i_q + 3'd1;
                    row_addr_d = row_addr_q + ADDR_WIDTH'(w_q);
                end else begin
                    j_d = j_q + 3'd1;
                end
            end
        end else if (adv_i) begin
            if (last_col) begin
                tr_d        = tr_q + DIM_WIDTH'(1);
                tc_d        = '0;
                trow_base_d = trow_base_q + band_step;
                tile_base_d = trow_base_q + band_step;
                row_addr_d  = trow_base_q + band_step;
            end else begin
                tc_d        = tc_q + DIM_WIDTH'(1);
                tile_base_d = tile_base_q + ADDR_WIDTH'(TILE_STRIDE);
                row_addr_d  = tile_base_q + ADDR_WIDTH'(TILE_STRIDE);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q         <= '0;
            w_q         <= '0;
            th_q        <= '0;
            tw_q        <= '0;
            tr_q        <= '0;
            tc_q        <= '0;
            i_q         <= '0;
            j_q         <= '0;
            slot_q      <= '0;
            trow_base_q <= '0;
            tile_base_q <= '0;
            row_addr_q  <= '0;
        end else begin
            h_q         <= h_d;
            w_q         <= w_d;
            th_q        <= th_d;
            tw_q        <= tw_d;
            tr_q        <= tr_d;
            tc_q        <= tc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            slot_q      <= slot_d;
            trow_base_q <= trow_base_d;
            tile_base_q <= tile_base_d;
            row_addr_q  <= row_addr_d;
        end
    end

endmodule

// File: rtl/winograd_tile_loader.sv
// winograd_tile_loader: fetches overlapping 6x6 zero-padded tiles (stride 4)
// from a 1-cycle-latency feature-map RAM and hands them out over valid/ready.
module winograd_tile_loader
    import winograd_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int DIM_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]  img_h,
    input  logic [DIM_WIDTH-1:0]  img_w,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [0:TILE_SIZE-1][0:TILE_SIZE-1][DATA_WIDTH-1:0] tile_out,
    output logic                  tile_valid,
    input  logic                  tile_ready,
    output logic [DIM_WIDTH-1:0]  tile_row,
    output logic [DIM_WIDTH-1:0]  tile_col,
    output logic                  last_tile,
    output logic                  busy,
    output logic                  done
);

    loader_state_e         state_q, state_d;

    logic                  ag_init, ag_run, ag_adv;
    logic                  ag_rd_en, ag_last_slot, ag_last_tile;
    logic [ADDR_WIDTH-1:0] ag_addr;
    logic [5:0]            ag_slot;
    logic [DIM_WIDTH-1:0]  ag_row, ag_col;

    // Slot bookkeeping delayed one cycle to line up with the RAM read data.
    logic                  cap_vld_q, cap_vld_d;
    logic                  cap_rd_q, cap_rd_d;
    logic [5:0]            cap_idx_q, cap_idx_d;

    logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_q;

    tile_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .init_i      (ag_init),
        .run_i       (ag_run),
        .adv_i       (ag_adv),
        .base_addr_i (base_addr),
        .img_h_i     (img_h),
        .img_w_i     (img_w),
        .rd_en_o     (ag_rd_en),
        .addr_o      (ag_addr),
        .slot_idx_o  (ag_slot),
        .last_slot_o (ag_last_slot),
        .tile_row_o  (ag_row),
        .tile_col_o  (ag_col),
        .last_tile_o (ag_last_tile)
    );

    // FSM next state and address-generator control.
    always_comb begin
        state_d = state_q;
        ag_init = 1'b0;
        ag_run  = 1'b0;
        ag_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ag_init = 1'b1;
                    state_d = (img_h == '0 || img_w == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                ag_run = 1'b1;
                if (ag_last_slot) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = PRESENT;
            end
            PRESENT: begin
                if (tile_ready) begin
                    if (ag_last_tile) begin
                        state_d = DONE;
                    end else begin
                        ag_adv  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next values for the read-data alignment pipeline.
    always_comb begin
        cap_vld_d = ag_run;
        cap_rd_d  = ag_rd_en;
        cap_idx_d = ag_slot;
    end

    // Read-data alignment pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_q <= 1'b0;
            cap_rd_q  <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            cap_vld_q <= cap_vld_d;
            cap_rd_q  <= cap_rd_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    // Tile register file: padded slots are written as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_q <= '0;
        end else if (cap_vld_q) begin
            tile_q[cap_idx_q] <= cap_rd_q ? mem_rdata : '0;
        end
    end

    // Present the flat register file as [row][col] and drive status outputs.
    always_comb begin
        tile_out = '0;
        for (int r = 0; r < TILE_SIZE; r++) begin
            for (int c = 0; c < TILE_SIZE; c++) begin
                tile_out[r][c] = tile_q[r*TILE_SIZE + c];
            end
        end
        mem_rd_en  = ag_rd_en;
        mem_addr   = ag_rd_en ? ag_addr : '0;
        tile_valid = (state_q == PRESENT);
        last_tile  = (state_q == PRESENT) && ag_last_tile;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        tile_row   = ag_row;
        tile_col   = ag_col;
    end

endmodule

// File: tb/tb_winograd_tile_loader.sv
// Randomized self-checking bench for winograd_tile_loader with a
// coordinate-level tile model and a behavioural 1-cycle-latency RAM.
module tb_winograd_tile_loader;

    localparam int DW   = 16;
    localparam int AW   = 12;
    localparam int DIMW = 7;
    localparam int TIMEOUT = 200;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [DIMW-1:0] img_h, img_w;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata;
    logic [0:5][0:5][DW-1:0] tile_out;
    logic            tile_valid, tile_ready;
    logic [DIMW-1:0] tile_row, tile_col;
    logic            last_tile, busy, done;

    logic [DW-1:0]   mem [0:4095];
    logic [0:5][0:5][DW-1:0] last_snap;
    int              n_checks = 0;
    int              n_fail   = 0;
    int              rd_low;

    always #5 clk = ~clk;

    winograd_tile_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DIMW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .img_h      (img_h),
        .img_w      (img_w),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .tile_out   (tile_out),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_row   (tile_row),
        .tile_col   (tile_col),
        .last_tile  (last_tile),
        .busy       (busy),
        .done       (done)
    );

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit in_img(int h, int w, int tr, int tc, int i, int j);
        int r = 4*tr - 1 + i;
        int c = 4*tc - 1 + j;
        return (r >= 0 && r < h && c >= 0 && c < w);
    endfunction

    function automatic logic [DW-1:0] ref_pix(int base, int h, int w, int tr, int tc, int i, int j);
        int r = 4*tr - 1 + i;
        int c = 4*tc - 1 + j;
        if (!in_img(h, w, tr, tc, i, j)) return '0;
        return mem[(base + r*w + c) % 4096];
    endfunction

    // One full frame: every tile checked against the model, optional
    // backpressure and an optional start pulse injected while busy.
    task automatic run_frame(int base, int h, int w, int hold_min, int hold_max, bit poke_start);
        int  th = (h + 3) / 4;
        int  tw = (w + 3) / 4;
        int  rd_cnt = 0;
        int  rd_exp = 0;
        int  n;
        int  hold;
        bit  stable;
        logic [0:5][0:5][DW-1:0] snap;
        rd_low    = 0;
        base_addr = AW'(base);
        img_h     = DIMW'(h);
        img_w     = DIMW'(w);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int tr = 0; tr < th; tr++) begin
            for (int tc = 0; tc < tw; tc++) begin
                n = 0;
                while (!tile_valid && n < TIMEOUT) begin
                    rd_cnt += int'(mem_rd_en);
                    rd_low += int'(mem_rd_en && mem_addr < 2048);
                    if (poke_start && tr == 0 && tc == 0 && n == 5) begin
                        start     = 1'b1;
                        base_addr = AW'(base + 100);
                        img_h     = DIMW'(h + 3);
                        img_w     = DIMW'(w + 2);
                    end
                    tick();
                    start = 1'b0;
                    n++;
                end
                chk($sformatf("latency t%0d,%0d", tr, tc), n, 37);
                if (!tile_valid) return;
                chk($sformatf("tile_row t%0d,%0d", tr, tc), tile_row, tr);
                chk($sformatf("tile_col t%0d,%0d", tr, tc), tile_col, tc);
                chk($sformatf("last_tile t%0d,%0d", tr, tc), last_tile, (tr == th-1 && tc == tw-1));
                chk($sformatf("rd_in_present t%0d,%0d", tr, tc), mem_rd_en, 0);
                for (int i = 0; i < 6; i++) begin
                    for (int j = 0; j < 6; j++) begin
                        rd_exp += int'(in_img(h, w, tr, tc, i, j));
                        chk($sformatf("elem t%0d,%0d[%0d][%0d]", tr, tc, i, j),
                            tile_out[i][j], ref_pix(base, h, w, tr, tc, i, j));
                    end
                end
                hold   = int'($urandom_range(hold_max, hold_min));
                snap   = tile_out;
                stable = 1'b1;
                for (int k = 0; k < hold; k++) begin
                    tick();
                    rd_cnt += int'(mem_rd_en);
                    if (tile_out !== snap || tile_row != DIMW'(tr) || tile_col != DIMW'(tc) ||
                        !tile_valid || mem_rd_en) stable = 1'b0;
                end
                if (hold > 0) chk($sformatf("hold_stable t%0d,%0d", tr, tc), stable, 1);
                last_snap  = tile_out;
                tile_ready = 1'b1;
                tick();
                tile_ready = 1'b0;
            end
        end
        chk("rd_count", rd_cnt, rd_exp);
        chk("done_pulse", done, 1);
        chk("valid_drop", tile_valid, 0);
        chk("busy_in_done", busy, 1);
        tick();
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, " tile_valid"}, tile_valid, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " mem_rd_en"}, mem_rd_en, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " tile_row"}, tile_row, 0);
        chk({tag, " tile_col"}, tile_col, 0);
        chk({tag, " last_tile"}, last_tile, 0);
        chk({tag, " tile_out_nonzero"}, (tile_out != '0), 0);
    endtask

    task automatic fill_test1();
        for (int a = 0; a < 16; a++) mem[a] = DW'(a + 1);
    endtask

    task automatic spot_test1();
        chk("t1 [1][1]", last_snap[1][1], 1);
        chk("t1 [1][4]", last_snap[1][4], 4);
        chk("t1 [4][4]", last_snap[4][4], 16);
        chk("t1 [0][0]", last_snap[0][0], 0);
        chk("t1 [5][5]", last_snap[5][5], 0);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
        rst        = 1'b1;
        start      = 1'b0;
        tile_ready = 1'b0;
        base_addr  = '0;
        img_h      = '0;
        img_w      = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_all_zero("reset");

        // 4x4, pixels 1..16.
        fill_test1();
        run_frame(0, 4, 4, 0, 0, 1'b0);
        spot_test1();

        // 8x8, pixel = r*8+c.
        for (int a = 0; a < 64; a++) mem[a] = DW'(a);
        run_frame(0, 8, 8, 0, 2, 1'b0);
        chk("t2 tile(1,1)[0][0]", last_snap[0][0], 27);
        chk("t2 tile(1,1)[5][0]", last_snap[5][0], 0);

        // 5x7 edge-padded grid.
        for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
        run_frame(200, 5, 7, 0, 1, 1'b0);

        // Backpressure of 10 cycles on every tile, plus a start poke while busy.
        run_frame(37, 8, 8, 10, 10, 1'b1);

        // Zero-width frame.
        base_addr = '0;
        img_h     = DIMW'(5);
        img_w     = '0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("zw done", done, 1);
        chk("zw busy", busy, 1);
        chk("zw valid", tile_valid, 0);
        chk("zw rd_en", mem_rd_en, 0);
        tick();
        chk("zw done_clear", done, 0);
        chk("zw idle", busy, 0);

        // Address wrap: 4x4 at 4090 touches 4090..4095 then 0..9.
        run_frame(4090, 4, 4, 0, 0, 1'b0);
        chk("wrap low reads", rd_low, 10);

        // Reset in the middle of FETCH, then a clean rerun of the 4x4 case.
        fill_test1();
        base_addr = '0;
        img_h     = DIMW'(4);
        img_w     = DIMW'(4);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        repeat (10) tick();
        chk("pre_rst busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_rst");
        tick();
        chk("post_rst no done", done, 0);
        run_frame(0, 4, 4, 0, 0, 1'b0);
        spot_test1();

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
            run_frame(int'($urandom_range(4095, 0)), int'($urandom_range(13, 1)),
                      int'($urandom_range(13, 1)), 0, 3, f[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
